data_mem_p: RTL and testbench
=============================

DATA_MEM_P -- requirements
Module: data_mem_p

Interface
REQ-001 Parameter DATA_W, default 32: data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 8: word-address width.
REQ-003 Parameter DEPTH, default 256: number of words; SHALL satisfy 1 <= DEPTH <= 2^ADDR_W.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  1  access request, qualified by ready.
REQ-007 wren  input  1  access type, active-low: 0 = write, 1 = read.
REQ-008 address  input  ADDR_W  word address.
REQ-009 w_data  input  DATA_W  write data.
REQ-010 be  input  DATA_W/8  byte enables for writes; bit i gates byte i.
REQ-011 ready  output  1  block accepts a request this cycle.
REQ-012 r_valid  output  1  one-cycle pulse: r_data holds read result.
REQ-013 r_data  output  DATA_W  registered read data.
REQ-014 err  output  1  one-cycle pulse: previous accepted access was out of range.
REQ-015 dbg_addr  input  ADDR_W  debug tap address, never modifies state.
REQ-016 dbg_data  output  DATA_W  combinational contents of word dbg_addr; 0 when dbg_addr >= DEPTH.

Function
REQ-017 FSM states: CLEAR, IDLE.
REQ-018 CLEAR: counter clr_idx writes 0 to word clr_idx each cycle, 0..DEPTH-1; after the DEPTH-1 write, next state IDLE; ready = 0 throughout.
REQ-019 IDLE: ready = 1; no return to CLEAR except by reset.
REQ-020 Access accepted iff req = 1 and ready = 1 at a rising edge; req while ready = 0 SHALL be ignored, not queued.
REQ-021 Accepted write (wren = 0, address < DEPTH): each byte i with be[i] = 1 takes w_data byte i at that edge; bytes with be[i] = 0 unchanged; be = 0 writes nothing, no error.
REQ-022 Accepted read (wren = 1, address < DEPTH): r_data = word contents at the accept edge, r_valid = 1 for exactly the following cycle; latency 1.
REQ-023 Write then read of the same address on consecutive accepted cycles: the read SHALL return the newly written bytes.
REQ-024 r_data SHALL hold its last value when r_valid = 0; writes do not pulse r_valid.
REQ-025 Accepted access with address >= DEPTH: no array change, err = 1 for the following cycle; if a read, r_valid = 1 and r_data = 0 in that cycle.
REQ-026 Back-to-back accepted accesses, one per cycle, SHALL be supported with no bubbles.
REQ-027 dbg_data SHALL reflect writes from the edge on which they commit.

Reset
REQ-028 rst_n = 0 SHALL asynchronously set state = CLEAR, clr_idx = 0, ready = 0, r_valid = 0, err = 0, r_data = 0.
REQ-029 Array contents are not reset asynchronously; zeroing occurs only through the CLEAR sweep after rst_n deasserts.
REQ-030 Reset asserted mid-sweep or mid-access SHALL abort it and restart the full CLEAR sweep from index 0; an in-flight r_valid/err pulse is dropped.

Verification
REQ-031 Release reset, DEPTH = 256 -> ready = 0 for exactly 256 cycles, then 1; dbg_data = 0 at every address.
REQ-032 Write address 0x90, w_data 0x000003DB, be = 4'b1111; next cycle read 0x90 -> r_valid pulse one cycle after accept, r_data = 0x000003DB.
REQ-033 Word 0x85 = 0x11223344; write w_data 0xAABBCCDD, be = 4'b0101 -> read returns 0x11BB33DD.
REQ-034 DEPTH = 200: read address 200 -> err = 1 and r_valid = 1 with r_data = 0 for one cycle; write address 250 -> err = 1, dbg_data at 250 and all valid words unchanged.
REQ-035 Reads of 0x82..0x8B issued on 10 consecutive cycles -> 10 consecutive r_valid cycles, data in issue order.
REQ-036 Assert rst_n = 0 at clr_idx = 100, hold 2 cycles, release -> ready low for full 256 cycles again; req during CLEAR has no effect.

Source files
------------

// File: rtl/data_mem_p_if.sv
// Bus bundle for data_mem_p: request/response handshake plus the read-only debug tap.
interface data_mem_p_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
);
   logic                  req;
   logic                  wren;
   logic [ADDR_W-1:0]     address;
   logic [DATA_W-1:0]     w_data;
   logic [DATA_W/8-1:0]   be;
   logic                  ready;
   logic                  r_valid;
   logic [DATA_W-1:0]     r_data;
   logic                  err;
   logic [ADDR_W-1:0]     dbg_addr;
   logic [DATA_W-1:0]     dbg_data;

   modport master (
      output req, wren, address, w_data, be, dbg_addr,
      input  ready, r_valid, r_data, err, dbg_data
   );

   modport slave (
      input  req, wren, address, w_data, be, dbg_addr,
      output ready, r_valid, r_data, err, dbg_data
   );
endinterface

// File: rtl/data_mem_p.sv
// Byte-enabled single-port data memory; zeroed by a hardware sweep after every reset,
// one-cycle read latency, range errors reported as a one-cycle pulse.
module data_mem_p #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input logic        clk,
   input logic        rst_n,
   data_mem_p_if.slave bus
);
   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST_X  = (ADDR_W + 1)'(DEPTH - 1);

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_IDLE  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
   logic                r_valid_q, r_valid_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   r_data_q, r_data_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                accept_s;
   logic                in_range_s;
   logic                dbg_in_range_s;
   logic                clr_en_s;
   logic                wr_en_s;
   logic [IDX_W-1:0]    addr_idx_s;
   logic [IDX_W-1:0]    clr_sel_s;
   logic [IDX_W-1:0]    dbg_idx_s;

   assign accept_s       = bus.req && (state_q == S_IDLE);
   assign in_range_s     = ({1'b0, bus.address} < DEPTH_X);
   assign dbg_in_range_s = ({1'b0, bus.dbg_addr} < DEPTH_X);
   assign addr_idx_s     = bus.address[IDX_W-1:0];
   assign clr_sel_s      = clr_idx_q[IDX_W-1:0];
   assign dbg_idx_s      = bus.dbg_addr[IDX_W-1:0];

   // Next-state, sweep control and response generation.
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      r_valid_d = 1'b0;
      err_d     = 1'b0;
      r_data_d  = r_data_q;
      clr_en_s  = 1'b0;
      wr_en_s   = 1'b0;
      case (state_q)
         S_CLEAR: begin
            clr_en_s = 1'b1;
            if ({1'b0, clr_idx_q} == LAST_X) begin
               state_d   = S_IDLE;
               clr_idx_d = {ADDR_W{1'b0}};
            end else begin
               clr_idx_d = clr_idx_q + ADDR_W'(1);
            end
         end
         S_IDLE: begin
            if (accept_s) begin
               if (!in_range_s) begin
                  err_d = 1'b1;
                  if (bus.wren) begin
                     r_valid_d = 1'b1;
                     r_data_d  = {DATA_W{1'b0}};
                  end else begin
                     r_data_d  = r_data_q;
                  end
               end else if (bus.wren) begin
                  r_valid_d = 1'b1;
                  r_data_d  = mem_q[addr_idx_s];
               end else begin
                  wr_en_s = 1'b1;
               end
            end else begin
               r_data_d = r_data_q;
            end
         end
         default: begin
            state_d   = S_CLEAR;
            clr_idx_d = {ADDR_W{1'b0}};
         end
      endcase
   end

   // Control and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_CLEAR;
         clr_idx_q <= {ADDR_W{1'b0}};
         r_valid_q <= 1'b0;
         err_q     <= 1'b0;
         r_data_q  <= {DATA_W{1'b0}};
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         r_valid_q <= r_valid_d;
         err_q     <= err_d;
         r_data_q  <= r_data_d;
      end
   end

   // Storage array: no reset, zeroed only by the sweep; bytes gated individually.
   always_ff @(posedge clk) begin
      if (clr_en_s) begin
         mem_q[clr_sel_s] <= {DATA_W{1'b0}};
      end else if (wr_en_s) begin
         for (int i = 0; i < BE_W; i++) begin
            if (bus.be[i]) begin
               mem_q[addr_idx_s][8*i +: 8] <= bus.w_data[8*i +: 8];
            end
         end
      end
   end

   assign bus.ready    = (state_q == S_IDLE);
   assign bus.r_valid  = r_valid_q;
   assign bus.err      = err_q;
   assign bus.r_data   = r_data_q;
   assign bus.dbg_data = dbg_in_range_s ? mem_q[dbg_idx_s] : {DATA_W{1'b0}};
endmodule

// File: tb/tb_data_mem_p.sv
// Scoreboard bench: instance A (DEPTH 256) for the main function, instance B (DEPTH 200) for range errors.
module tb_data_mem_p;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   data_mem_p_if #(.DATA_W(32), .ADDR_W(8)) bus_a ();
   data_mem_p_if #(.DATA_W(32), .ADDR_W(8)) bus_b ();

   data_mem_p #(.DATA_W(32), .ADDR_W(8), .DEPTH(256)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   data_mem_p #(.DATA_W(32), .ADDR_W(8), .DEPTH(200)) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   typedef struct packed {
      logic        rv;
      logic        er;
      logic [31:0] d;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e_a, e_b;
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cmp(input string tag, input exp_t e, input logic rv, input logic er, input logic [31:0] rd);
      check({tag, "_r_valid"}, 32'(rv), 32'(e.rv));
      check({tag, "_err"}, 32'(er), 32'(e.er));
      if (e.rv) check({tag, "_r_data"}, rd, e.d);
   endtask

   // Monitors: every r_valid/err pulse must match the next queued expectation.
   always @(negedge clk) begin
      if (bus_a.r_valid || bus_a.err) begin
         if (q_a.size() == 0) begin
            check("a_unexpected_pulse", {30'b0, bus_a.r_valid, bus_a.err}, 32'h0);
         end else begin
            e_a = q_a.pop_front();
            cmp("a", e_a, bus_a.r_valid, bus_a.err, bus_a.r_data);
         end
      end
   end

   always @(negedge clk) begin
      if (bus_b.r_valid || bus_b.err) begin
         if (q_b.size() == 0) begin
            check("b_unexpected_pulse", {30'b0, bus_b.r_valid, bus_b.err}, 32'h0);
         end else begin
            e_b = q_b.pop_front();
            cmp("b", e_b, bus_b.r_valid, bus_b.err, bus_b.r_data);
         end
      end
   end

   task automatic acc(input bit sel, input logic wr_n, input logic [7:0] ad, input logic [31:0] d,
                      input logic [3:0] b, input logic exp_er, input logic [31:0] exp_d);
      @(negedge clk);
      if (sel) begin
         bus_b.req = 1'b1; bus_b.wren = wr_n; bus_b.address = ad; bus_b.w_data = d; bus_b.be = b;
         if (wr_n || exp_er) q_b.push_back('{rv: wr_n, er: exp_er, d: exp_d});
      end else begin
         bus_a.req = 1'b1; bus_a.wren = wr_n; bus_a.address = ad; bus_a.w_data = d; bus_a.be = b;
         if (wr_n || exp_er) q_a.push_back('{rv: wr_n, er: exp_er, d: exp_d});
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      bus_a.req = 1'b0;
      bus_b.req = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic scan(input bit sel, input logic [7:0] a1, input logic [31:0] v1, input string name);
      logic [7:0]  ad;
      logic [31:0] ex, got;
      for (int k = 0; k < 256; k++) begin
         ad = 8'(k);
         ex = (ad == a1) ? v1 : 32'h0;
         if (sel) bus_b.dbg_addr = ad; else bus_a.dbg_addr = ad;
         #1;
         got = sel ? bus_b.dbg_data : bus_a.dbg_data;
         check($sformatf("%s[%0d]", name, k), got, ex);
      end
   endtask

   // Called at the negedge where rst_n is released; counts cycles each instance holds ready low.
   task automatic count_ready(input string tag, input bit drop_req_a);
      int ca, cb;
      ca = 0;
      cb = 0;
      for (int n = 0; n < 1000 && !(bus_a.ready && bus_b.ready); n++) begin
         if (!bus_a.ready) ca++;
         if (!bus_b.ready) cb++;
         @(negedge clk);
      end
      if (drop_req_a) bus_a.req = 1'b0;
      check({tag, "_a_ready_low_cycles"}, 32'(ca), 32'd256);
      check({tag, "_b_ready_low_cycles"}, 32'(cb), 32'd200);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},   32'(bus_a.ready),   32'h0);
      check({tag, "_r_valid"}, 32'(bus_a.r_valid), 32'h0);
      check({tag, "_err"},     32'(bus_a.err),     32'h0);
      check({tag, "_r_data"},  bus_a.r_data,       32'h0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      bus_a.req = 1'b0; bus_a.wren = 1'b1; bus_a.address = 8'h0; bus_a.w_data = 32'h0; bus_a.be = 4'h0;
      bus_b.req = 1'b0; bus_b.wren = 1'b1; bus_b.address = 8'h0; bus_b.w_data = 32'h0; bus_b.be = 4'h0;
      bus_a.dbg_addr = 8'h0;
      bus_b.dbg_addr = 8'h0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst0");
      rst_n = 1'b1;
      count_ready("init", 1'b0);
      scan(1'b0, 8'h00, 32'h0, "a_clear_dbg");
      scan(1'b1, 8'h00, 32'h0, "b_clear_dbg");

      // Full write then immediate read of the same word.
      acc(1'b0, 1'b0, 8'h90, 32'h0000_03DB, 4'b1111, 1'b0, 32'h0);
      acc(1'b0, 1'b1, 8'h90, 32'h0,         4'b0000, 1'b0, 32'h0000_03DB);
      // Partial byte write, and be=0 leaving the word untouched.
      acc(1'b0, 1'b0, 8'h85, 32'h1122_3344, 4'b1111, 1'b0, 32'h0);
      acc(1'b0, 1'b0, 8'h85, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0);
      acc(1'b0, 1'b1, 8'h85, 32'h0,         4'b0000, 1'b0, 32'h11BB_33DD);
      acc(1'b0, 1'b0, 8'h85, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h0);
      acc(1'b0, 1'b1, 8'h85, 32'h0,         4'b0000, 1'b0, 32'h11BB_33DD);
      // Back-to-back writes then reads across 0x82..0x8B.
      for (int i = 0; i < 10; i++)
         acc(1'b0, 1'b0, 8'(8'h82 + i), 32'h5A00_0000 + 32'(i), 4'b1111, 1'b0, 32'h0);
      for (int i = 0; i < 10; i++)
         acc(1'b0, 1'b1, 8'(8'h82 + i), 32'h0, 4'b0000, 1'b0, 32'h5A00_0000 + 32'(i));
      idle(3);
      check("a_r_data_hold", bus_a.r_data, 32'h5A00_0009);
      check("a_r_valid_idle", 32'(bus_a.r_valid), 32'h0);
      check("a_queue_drained", 32'(q_a.size()), 32'h0);

      // Range boundary on the 200-word instance.
      acc(1'b1, 1'b0, 8'd199, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h0);
      acc(1'b1, 1'b1, 8'd199, 32'h0,         4'b0000, 1'b0, 32'hCAFE_F00D);
      acc(1'b1, 1'b1, 8'd200, 32'h0,         4'b0000, 1'b1, 32'h0);
      acc(1'b1, 1'b0, 8'd250, 32'h1234_5678, 4'b1111, 1'b1, 32'h0);
      acc(1'b1, 1'b0, 8'd200, 32'hFFFF_FFFF, 4'b1111, 1'b1, 32'h0);
      acc(1'b1, 1'b1, 8'd255, 32'h0,         4'b0000, 1'b1, 32'h0);
      acc(1'b1, 1'b1, 8'd0,   32'h0,         4'b0000, 1'b0, 32'h0);
      idle(3);
      check("b_queue_drained", 32'(q_b.size()), 32'h0);
      scan(1'b1, 8'd199, 32'hCAFE_F00D, "b_after_err_dbg");

      // Reset, then abort the sweep at index 100 with req held high throughout.
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst1");
      repeat (2) @(negedge clk);
      bus_a.req = 1'b1; bus_a.wren = 1'b0; bus_a.address = 8'h10; bus_a.w_data = 32'hFFFF_FFFF; bus_a.be = 4'hF;
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      count_ready("resweep", 1'b1);
      idle(2);
      scan(1'b0, 8'h00, 32'h0, "a_resweep_dbg");
      check("a_queue_final", 32'(q_a.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
